i2c_rw_seq: RTL

I2C_RW_SEQ -- requirements
Module: i2c_rw_seq

---
 rtl/i2c_rw_seq_pkg.sv | 23 ++
 rtl/sync_fifo_8x16.sv | 44 ++++
 rtl/i2c_rw_seq.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/i2c_rw_seq_pkg.sv
// Shared definitions for the EEPROM write/read-back sequencer.
// Holds the state encoding, FIFO geometry and default timing constants.
package i2c_rw_seq_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_WAIT = 3'd1,
        WR_BUSY = 3'd2,
        RD_WAIT = 3'd3,
        RD_BUSY = 3'd4
    } state_t;

    localparam int FIFO_WIDTH = 8;
    localparam int FIFO_DEPTH = 16;
    localparam int FIFO_AW    = 4;

    localparam logic [7:0]  DEF_DATA_NUM      = 8'd10;
    localparam logic [15:0] DEF_START_ADDR    = 16'h0000;
    localparam logic [7:0]  DEF_WR_DATA_BASE  = 8'hA0;
    localparam logic [17:0] DEF_CNT_START_MAX = 18'd250_000;
    localparam logic [25:0] DEF_CNT_DISP_MAX  = 26'd25_000_000;

endpackage

// File: rtl/sync_fifo_8x16.sv
// Single-clock 8-bit x 16-entry FIFO with first-word-fall-through read data.
// A push while full is accepted only when a pop happens in the same cycle.
module sync_fifo_8x16
    import i2c_rw_seq_pkg::*;
(
    input  logic                  sys_clk,
    input  logic                  sys_rst_n,
    input  logic                  push,
    input  logic                  pop,
    input  logic [FIFO_WIDTH-1:0] din,
    output logic [FIFO_WIDTH-1:0] dout,
    output logic                  full,
    output logic                  empty
);

    logic [FIFO_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [FIFO_AW:0]      wr_ptr;
    logic [FIFO_AW:0]      rd_ptr;
    logic                  do_push;
    logic                  do_pop;

    // The extra pointer bit distinguishes full from empty when the indices match.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[FIFO_AW] != rd_ptr[FIFO_AW]) &&
                     (wr_ptr[FIFO_AW-1:0] == rd_ptr[FIFO_AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr[FIFO_AW-1:0]];

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (do_push) mem[wr_ptr[FIFO_AW-1:0]] <= din;
    end

endmodule

// File: rtl/i2c_rw_seq.sv
// Sequences byte-wise EEPROM write and read bursts through an I2C controller
// and trickles read-back bytes out of a FIFO at a slow display rate.
module i2c_rw_seq
    import i2c_rw_seq_pkg::*;
#(
    parameter logic [7:0]  DATA_NUM      = DEF_DATA_NUM,
    parameter logic [15:0] START_ADDR    = DEF_START_ADDR,
    parameter logic [7:0]  WR_DATA_BASE  = DEF_WR_DATA_BASE,
    parameter logic [17:0] CNT_START_MAX = DEF_CNT_START_MAX,
    parameter logic [25:0] CNT_DISP_MAX  = DEF_CNT_DISP_MAX
)(
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic        write,
    input  logic        read,
    input  logic        i2c_end,
    input  logic [7:0]  rd_data,
    output logic        wr_en,
    output logic        rd_en,
    output logic        i2c_start,
    output logic [15:0] byte_addr,
    output logic [7:0]  wr_data,
    output logic [7:0]  fifo_rd_data,
    output logic        fifo_rd_valid,
    output logic        overflow
);

    state_t      state;
    state_t      next_state;
    logic [17:0] cnt_wait;
    logic [7:0]  byte_cnt;
    logic [25:0] cnt_disp;

    logic        wait_done;
    logic        last_byte;
    logic        in_wait;
    logic        in_busy;

    logic        fifo_push;
    logic        fifo_pop;
    logic        fifo_full;
    logic        fifo_empty;
    logic [7:0]  fifo_dout;

    assign wait_done = (cnt_wait == CNT_START_MAX - 18'd1);
    assign last_byte = (byte_cnt == DATA_NUM - 8'd1);
    assign in_wait   = (state == WR_WAIT) || (state == RD_WAIT);
    assign in_busy   = (state == WR_BUSY) || (state == RD_BUSY);

    assign wr_en     = (state == WR_WAIT) || (state == WR_BUSY);
    assign rd_en     = (state == RD_WAIT) || (state == RD_BUSY);
    assign byte_addr = START_ADDR + {8'd0, byte_cnt};
    assign wr_data   = WR_DATA_BASE + byte_cnt;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) state <= IDLE;
        else            state <= next_state;
    end

    // Write has priority over read; pulses outside IDLE are simply not looked at.
    always_comb begin
        next_state = state;
        i2c_start  = 1'b0;
        case (state)
            IDLE: begin
                if (write)     next_state = WR_WAIT;
                else if (read) next_state = RD_WAIT;
            end
            WR_WAIT: begin
                if (wait_done) begin
                    i2c_start  = 1'b1;
                    next_state = WR_BUSY;
                end
            end
            WR_BUSY: begin
                if (i2c_end) next_state = last_byte ? IDLE : WR_WAIT;
            end
            RD_WAIT: begin
                if (wait_done) begin
                    i2c_start  = 1'b1;
                    next_state = RD_BUSY;
                end
            end
            RD_BUSY: begin
                if (i2c_end) next_state = last_byte ? IDLE : RD_WAIT;
            end
            default: next_state = IDLE;
        endcase
    end

    // The idle gap gives the EEPROM time to finish its internal write cycle.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            cnt_wait <= '0;
        end else if (in_wait) begin
            cnt_wait <= wait_done ? 18'd0 : cnt_wait + 18'd1;
        end else begin
            cnt_wait <= '0;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            byte_cnt <= '0;
        end else if (in_busy && i2c_end) begin
            byte_cnt <= last_byte ? 8'd0 : byte_cnt + 8'd1;
        end
    end

    assign fifo_push = (state == RD_BUSY) && i2c_end;
    assign fifo_pop  = !fifo_empty && (cnt_disp == CNT_DISP_MAX - 26'd1);

    sync_fifo_8x16 u_fifo (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .push      (fifo_push),
        .pop       (fifo_pop),
        .din       (rd_data),
        .dout      (fifo_dout),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // A push into a full FIFO is lost unless a pop frees the slot in the same cycle.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            overflow <= 1'b0;
        end else if (fifo_push && fifo_full && !fifo_pop) begin
            overflow <= 1'b1;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            cnt_disp <= '0;
        end else if (fifo_empty || fifo_pop) begin
            cnt_disp <= '0;
        end else begin
            cnt_disp <= cnt_disp + 26'd1;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            fifo_rd_valid <= 1'b0;
            fifo_rd_data  <= '0;
        end else begin
            fifo_rd_valid <= fifo_pop;
            if (fifo_pop) fifo_rd_data <= fifo_dout;
        end
    end

endmodule
